pipe_ctrl_regs: RTL and testbench

PIPE_CTRL_REGS -- requirements
Module: pipe_ctrl_regs

---
 rtl/pipe_ctrl_regs.sv | 123 ++++++++++++
 tb/tb_pipe_ctrl_regs.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_regs.sv
// Control-side pipeline registers (ID/EX, EX/MEM, MEM/WB) for a 5-stage core,
// with stall/flush handling and retire/stall/flush statistics counters.
module pipe_ctrl_regs (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Wreg,
   input  logic        Reg2reg,
   input  logic        Wmem,
   input  logic        Aluqb,
   input  logic        Reglui,
   input  logic [1:0]  Aluc,
   input  logic [5:0]  Op,
   input  logic [4:0]  Rd,
   input  logic        STALL,
   input  logic        Condep,
   output logic        eWreg,
   output logic        eReg2reg,
   output logic        eWmem,
   output logic        eAluqb,
   output logic        eReglui,
   output logic [1:0]  eAluc,
   output logic [5:0]  eOp,
   output logic [4:0]  eRd,
   output logic        mWreg,
   output logic        mReg2reg,
   output logic        mWmem,
   output logic [4:0]  mRd,
   output logic        wWreg,
   output logic        wReg2reg,
   output logic [4:0]  wRd,
   output logic        PcEn,
   output logic        IrEn,
   output logic [31:0] RetireCnt,
   output logic [15:0] StallCnt,
   output logic [15:0] FlushCnt
);

   logic vld_p0, vld_p1, vld_p2;
   logic load_id;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // A flush wins over a stall so the redirected fetch is not held back.
   assign PcEn    = ~STALL | ~Condep;
   assign IrEn    = ~STALL | ~Condep;
   assign load_id = Condep & ~STALL;

   // ID/EX
   always_ff @(posedge Clk) begin
      if (Rst || !load_id) begin
         vld_p0   <= 1'b0;
         eWreg    <= 1'b0;
         eReg2reg <= 1'b1;
         eWmem    <= 1'b0;
         eAluqb   <= 1'b0;
         eReglui  <= 1'b0;
         eAluc    <= 2'b00;
         eOp      <= 6'b000000;
         eRd      <= 5'b00000;
      end else begin
         vld_p0   <= 1'b1;
         eWreg    <= Wreg;
         eReg2reg <= Reg2reg;
         eWmem    <= Wmem;
         eAluqb   <= Aluqb;
         eReglui  <= Reglui;
         eAluc    <= Aluc;
         eOp      <= Op;
         eRd      <= Rd;
      end
   end

   // EX/MEM
   always_ff @(posedge Clk) begin
      if (Rst) begin
         vld_p1   <= 1'b0;
         mWreg    <= 1'b0;
         mReg2reg <= 1'b1;
         mWmem    <= 1'b0;
         mRd      <= 5'b00000;
      end else begin
         vld_p1   <= vld_p0;
         mWreg    <= eWreg;
         mReg2reg <= eReg2reg;
         mWmem    <= eWmem;
         mRd      <= eRd;
      end
   end

   // MEM/WB
   always_ff @(posedge Clk) begin
      if (Rst) begin
         vld_p2   <= 1'b0;
         wWreg    <= 1'b0;
         wReg2reg <= 1'b1;
         wRd      <= 5'b00000;
      end else begin
         vld_p2   <= vld_p1;
         wWreg    <= mWreg;
         wReg2reg <= mReg2reg;
         wRd      <= mRd;
      end
   end

   // Statistics: a simultaneous stall and flush counts only as a flush.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         RetireCnt <= 32'd0;
         StallCnt  <= 16'd0;
         FlushCnt  <= 16'd0;
      end else begin
         if (vld_p2)
            RetireCnt <= RetireCnt + 32'd1;
         if (!Condep)
            FlushCnt <= sat_inc16(FlushCnt);
         else if (STALL)
            StallCnt <= sat_inc16(StallCnt);
      end
   end

endmodule

// File: tb/tb_pipe_ctrl_regs.sv
// Bench for pipe_ctrl_regs: directed vector table, counter saturation/wrap
// sequences and a randomized run against a queue-style pipeline model.
module tb_pipe_ctrl_regs;

   logic        Clk = 1'b0;
   logic        Rst, Wreg, Reg2reg, Wmem, Aluqb, Reglui, STALL, Condep;
   logic [1:0]  Aluc;
   logic [5:0]  Op;
   logic [4:0]  Rd;
   logic        eWreg, eReg2reg, eWmem, eAluqb, eReglui;
   logic [1:0]  eAluc;
   logic [5:0]  eOp;
   logic [4:0]  eRd;
   logic        mWreg, mReg2reg, mWmem;
   logic [4:0]  mRd;
   logic        wWreg, wReg2reg;
   logic [4:0]  wRd;
   logic        PcEn, IrEn;
   logic [31:0] RetireCnt;
   logic [15:0] StallCnt, FlushCnt;

   pipe_ctrl_regs dut (
      .Clk(Clk), .Rst(Rst), .Wreg(Wreg), .Reg2reg(Reg2reg), .Wmem(Wmem),
      .Aluqb(Aluqb), .Reglui(Reglui), .Aluc(Aluc), .Op(Op), .Rd(Rd),
      .STALL(STALL), .Condep(Condep),
      .eWreg(eWreg), .eReg2reg(eReg2reg), .eWmem(eWmem), .eAluqb(eAluqb),
      .eReglui(eReglui), .eAluc(eAluc), .eOp(eOp), .eRd(eRd),
      .mWreg(mWreg), .mReg2reg(mReg2reg), .mWmem(mWmem), .mRd(mRd),
      .wWreg(wWreg), .wReg2reg(wReg2reg), .wRd(wRd),
      .PcEn(PcEn), .IrEn(IrEn), .RetireCnt(RetireCnt),
      .StallCnt(StallCnt), .FlushCnt(FlushCnt)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      bit       v;
      bit       wreg, r2r, wmem, aluqb, reglui;
      bit [1:0] aluc;
      bit [5:0] op;
      bit [4:0] rd;
   } ins_t;

   typedef struct {
      bit       rst, stall, condep, wreg, r2r;
      bit [5:0] op;
      bit [4:0] rd;
      bit       pcen;
      bit [4:0] e_rd;
      bit       e_wreg, e_r2r;
      bit [4:0] m_rd, w_rd;
      int       ret, st, fl;
   } vec_t;

   int n_chk = 0;
   int n_fail = 0;

   // Model state: slot 0 = EX, 1 = MEM, 2 = WB.
   ins_t        pipe [3];
   int unsigned m_ret;
   int          m_st, m_fl;

   function automatic ins_t bubble();
      ins_t b;
      b = '{default: '0};
      b.r2r = 1'b1;
      return b;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic model_edge(input bit r, input bit s, input bit c, input ins_t i);
      if (r) begin
         for (int k = 0; k < 3; k++) pipe[k] = bubble();
         m_ret = 0; m_st = 0; m_fl = 0;
      end else begin
         if (pipe[2].v) m_ret = m_ret + 1;
         if (!c) m_fl = (m_fl >= 65535) ? 65535 : m_fl + 1;
         else if (s) m_st = (m_st >= 65535) ? 65535 : m_st + 1;
         pipe[2] = pipe[1];
         pipe[1] = pipe[0];
         if (!c || s) pipe[0] = bubble();
         else begin
            pipe[0] = i;
            pipe[0].v = 1'b1;
         end
      end
   endtask

   // Apply inputs at negedge, sample the fetch enables, then take the edge.
   task automatic drive(input bit r, input bit s, input bit c, input ins_t i,
                        output bit pc, output bit ir);
      @(negedge Clk);
      Rst = r; STALL = s; Condep = c;
      Wreg = i.wreg; Reg2reg = i.r2r; Wmem = i.wmem; Aluqb = i.aluqb;
      Reglui = i.reglui; Aluc = i.aluc; Op = i.op; Rd = i.rd;
      #1;
      pc = PcEn; ir = IrEn;
      @(posedge Clk);
      model_edge(r, s, c, i);
      #1;
   endtask

   task automatic chk_model(input string tag);
      chk({tag, " e_stage"}, {15'd0, eWreg, eReg2reg, eWmem, eAluqb, eReglui, eAluc, eOp, eRd},
          {15'd0, pipe[0].wreg, pipe[0].r2r, pipe[0].wmem, pipe[0].aluqb, pipe[0].reglui,
           pipe[0].aluc, pipe[0].op, pipe[0].rd});
      chk({tag, " m_stage"}, {24'd0, mWreg, mReg2reg, mWmem, mRd},
          {24'd0, pipe[1].wreg, pipe[1].r2r, pipe[1].wmem, pipe[1].rd});
      chk({tag, " w_stage"}, {25'd0, wWreg, wReg2reg, wRd},
          {25'd0, pipe[2].wreg, pipe[2].r2r, pipe[2].rd});
      chk({tag, " RetireCnt"}, RetireCnt, m_ret);
      chk({tag, " StallCnt"}, {16'd0, StallCnt}, m_st);
      chk({tag, " FlushCnt"}, {16'd0, FlushCnt}, m_fl);
   endtask

   vec_t tbl [15];

   initial begin
      ins_t in;
      bit   pc, ir, r, s, c;

      Rst = 1'b1; STALL = 1'b0; Condep = 1'b1;
      Wreg = 0; Reg2reg = 0; Wmem = 0; Aluqb = 0; Reglui = 0;
      Aluc = '0; Op = '0; Rd = '0;
      for (int k = 0; k < 3; k++) pipe[k] = bubble();
      m_ret = 0; m_st = 0; m_fl = 0;

      //           rst st cd wr r2r op     rd  | pc eRd eW eR2 mRd wRd ret st fl
      tbl[0]  = '{1, 0, 1, 1, 0, 6'h01, 7,  1, 0,  0, 1, 0,  0,  0, 0, 0};
      tbl[1]  = '{0, 0, 1, 1, 1, 6'h00, 3,  1, 3,  1, 1, 0,  0,  0, 0, 0};
      tbl[2]  = '{0, 0, 1, 1, 0, 6'h23, 5,  1, 5,  1, 0, 3,  0,  0, 0, 0};
      tbl[3]  = '{0, 1, 1, 1, 1, 6'h00, 9,  0, 0,  0, 1, 5,  3,  0, 1, 0};
      tbl[4]  = '{0, 0, 1, 1, 1, 6'h00, 9,  1, 9,  1, 1, 0,  5,  1, 1, 0};
      tbl[5]  = '{0, 0, 1, 0, 1, 6'h04, 0,  1, 0,  0, 1, 9,  0,  2, 1, 0};
      tbl[6]  = '{0, 0, 0, 1, 1, 6'h00, 11, 1, 0,  0, 1, 0,  9,  2, 1, 1};
      tbl[7]  = '{0, 1, 0, 1, 1, 6'h00, 12, 1, 0,  0, 1, 0,  0,  3, 1, 2};
      tbl[8]  = '{0, 0, 1, 1, 1, 6'h00, 13, 1, 13, 1, 1, 0,  0,  4, 1, 2};
      tbl[9]  = '{0, 0, 1, 1, 1, 6'h00, 14, 1, 14, 1, 1, 13, 0,  4, 1, 2};
      tbl[10] = '{0, 0, 1, 1, 1, 6'h00, 15, 1, 15, 1, 1, 14, 13, 4, 1, 2};
      tbl[11] = '{1, 1, 1, 1, 1, 6'h00, 16, 0, 0,  0, 1, 0,  0,  0, 0, 0};
      tbl[12] = '{0, 1, 1, 1, 1, 6'h00, 17, 0, 0,  0, 1, 0,  0,  0, 1, 0};
      tbl[13] = '{0, 1, 1, 1, 1, 6'h00, 17, 0, 0,  0, 1, 0,  0,  0, 2, 0};
      tbl[14] = '{0, 1, 1, 1, 1, 6'h00, 17, 0, 0,  0, 1, 0,  0,  0, 3, 0};

      for (int n = 0; n < 15; n++) begin
         in = '{default: '0};
         in.wreg = tbl[n].wreg; in.r2r = tbl[n].r2r; in.op = tbl[n].op; in.rd = tbl[n].rd;
         drive(tbl[n].rst, tbl[n].stall, tbl[n].condep, in, pc, ir);
         chk($sformatf("v%0d PcEn", n), {31'd0, pc}, {31'd0, tbl[n].pcen});
         chk($sformatf("v%0d IrEn", n), {31'd0, ir}, {31'd0, tbl[n].pcen});
         chk($sformatf("v%0d eRd", n), {27'd0, eRd}, {27'd0, tbl[n].e_rd});
         chk($sformatf("v%0d eWreg", n), {31'd0, eWreg}, {31'd0, tbl[n].e_wreg});
         chk($sformatf("v%0d eReg2reg", n), {31'd0, eReg2reg}, {31'd0, tbl[n].e_r2r});
         chk($sformatf("v%0d mRd", n), {27'd0, mRd}, {27'd0, tbl[n].m_rd});
         chk($sformatf("v%0d wRd", n), {27'd0, wRd}, {27'd0, tbl[n].w_rd});
         chk($sformatf("v%0d RetireCnt", n), RetireCnt, tbl[n].ret);
         chk($sformatf("v%0d StallCnt", n), {16'd0, StallCnt}, tbl[n].st);
         chk($sformatf("v%0d FlushCnt", n), {16'd0, FlushCnt}, tbl[n].fl);
      end

      // StallCnt saturation: 65534 stalls, then two more edges.
      in = bubble();
      drive(1, 0, 1, in, pc, ir);
      @(negedge Clk);
      Rst = 1'b0; STALL = 1'b1; Condep = 1'b1;
      repeat (65534) @(posedge Clk);
      #1 chk("stall_cnt_fffe", {16'd0, StallCnt}, 32'h0000FFFE);
      @(posedge Clk);
      #1 chk("stall_cnt_ffff", {16'd0, StallCnt}, 32'h0000FFFF);
      @(posedge Clk);
      #1 chk("stall_cnt_sat", {16'd0, StallCnt}, 32'h0000FFFF);

      // RetireCnt wrap: one valid instruction reaches WB, counter preset to all-ones.
      drive(1, 0, 1, in, pc, ir);
      in = '{default: '0};
      in.wreg = 1'b1; in.rd = 5'd1;
      drive(0, 0, 1, in, pc, ir);
      in = bubble();
      drive(0, 1, 1, in, pc, ir);
      drive(0, 1, 1, in, pc, ir);
      chk("wrap_w_valid_rd", {27'd0, wRd}, 32'd1);
      force dut.RetireCnt = 32'hFFFFFFFF;
      #2;
      release dut.RetireCnt;
      drive(0, 1, 1, in, pc, ir);
      chk("retire_wrap", RetireCnt, 32'd0);
      drive(0, 1, 1, in, pc, ir);
      chk("retire_after_wrap", RetireCnt, 32'd0);

      // Randomized run against the model.
      in = bubble();
      drive(1, 0, 1, in, pc, ir);
      chk_model("rnd_reset");
      for (int n = 0; n < 2000; n++) begin
         r = ($urandom_range(0, 63) == 0);
         s = ($urandom_range(0, 3) == 0);
         c = ($urandom_range(0, 7) != 0);
         in.v = 1'b0;
         in.wreg = 1'($urandom); in.r2r = 1'($urandom); in.wmem = 1'($urandom);
         in.aluqb = 1'($urandom); in.reglui = 1'($urandom);
         in.aluc = 2'($urandom); in.op = 6'($urandom); in.rd = 5'($urandom);
         drive(r, s, c, in, pc, ir);
         chk("rnd PcEn", {31'd0, pc}, {31'd0, (s && c) ? 1'b0 : 1'b1});
         chk("rnd IrEn", {31'd0, ir}, {31'd0, (s && c) ? 1'b0 : 1'b1});
         chk_model("rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
